// File: rtl/div_reservation_station.sv
// ============================================================================
//  Module   : div_reservation_station (with div_rs_pkg)
//  Brief    : Tag-matching reservation station feeding the integer divider;
//             captures operands from the CDB and issues lowest-index ready slot.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_rs_pkg;
    typedef struct packed {
        logic is_signed;
        logic is_rem;
    } div_decode_t;
endpackage

module div_reservation_station
    import div_rs_pkg::*;
#(
    parameter int RS_ID_WIDTH = 5,
    parameter int ENTRIES     = 4,
    parameter int RS_ID_BASE  = 0
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic                   op1_valid,
    input  logic                   op2_valid,
    input  logic [31:0]            op1_value,
    input  logic [31:0]            op2_value,
    input  logic [RS_ID_WIDTH-1:0] op1_rs_id,
    input  logic [RS_ID_WIDTH-1:0] op2_rs_id,
    input  logic [4:0]             result_reg_addr_in,
    input  div_decode_t            control_in,
    output logic [RS_ID_WIDTH-1:0] alloc_rs_id,

    input  logic                   cdb_valid,
    input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
    input  logic [31:0]            cdb_result,

    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [RS_ID_WIDTH-1:0] rs_id_out,
    output logic [4:0]             result_reg_addr_out,
    output logic [31:0]            op1_out,
    output logic [31:0]            op2_out,
    output div_decode_t            control_out
);

    localparam int c_IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [RS_ID_WIDTH-1:0] c_BASE_ID = RS_ID_WIDTH'(RS_ID_BASE);

    logic [ENTRIES-1:0]     r_busy;
    logic [ENTRIES-1:0]     r_op1_v;
    logic [ENTRIES-1:0]     r_op2_v;
    logic [31:0]            r_op1_val [ENTRIES];
    logic [31:0]            r_op2_val [ENTRIES];
    logic [RS_ID_WIDTH-1:0] r_op1_tag [ENTRIES];
    logic [RS_ID_WIDTH-1:0] r_op2_tag [ENTRIES];
    logic [4:0]             r_dst     [ENTRIES];
    div_decode_t            r_ctrl    [ENTRIES];

    logic [ENTRIES-1:0]     w_ready;
    logic                   w_free_any;
    logic [c_IDX_W-1:0]     w_free_idx;
    logic [c_IDX_W-1:0]     w_out_idx;
    logic                   w_dispatch;
    logic                   w_issue;
    logic                   w_byp1;
    logic                   w_byp2;

    // Priority encoders: descending scan leaves the lowest matching index.
    always_comb begin
        w_ready    = '0;
        w_free_any = 1'b0;
        w_free_idx = '0;
        w_out_idx  = '0;
        for (int k = ENTRIES - 1; k >= 0; k--) begin
            w_ready[k] = r_busy[k] & r_op1_v[k] & r_op2_v[k];
            if (!r_busy[k]) begin
                w_free_any = 1'b1;
                w_free_idx = c_IDX_W'(k);
            end
            if (r_busy[k] && r_op1_v[k] && r_op2_v[k]) begin
                w_out_idx = c_IDX_W'(k);
            end
        end
    end

    assign input_ready  = w_free_any;
    assign alloc_rs_id  = c_BASE_ID + RS_ID_WIDTH'(w_free_idx);
    assign output_valid = |w_ready;
    assign w_dispatch   = input_valid & w_free_any;
    assign w_issue      = output_valid & output_ready;
    assign w_byp1       = !op1_valid && cdb_valid && (op1_rs_id == cdb_rs_id);
    assign w_byp2       = !op2_valid && cdb_valid && (op2_rs_id == cdb_rs_id);

    assign rs_id_out           = output_valid ? c_BASE_ID + RS_ID_WIDTH'(w_out_idx) : '0;
    assign result_reg_addr_out = output_valid ? r_dst[w_out_idx]     : '0;
    assign op1_out             = output_valid ? r_op1_val[w_out_idx] : '0;
    assign op2_out             = output_valid ? r_op2_val[w_out_idx] : '0;
    assign control_out         = output_valid ? r_ctrl[w_out_idx]    : '0;

    // The issuing slot is busy at cycle start, so it can never be the dispatch target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy  <= '0;
            r_op1_v <= '0;
            r_op2_v <= '0;
            for (int k = 0; k < ENTRIES; k++) begin
                r_op1_val[k] <= '0;
                r_op2_val[k] <= '0;
                r_op1_tag[k] <= '0;
                r_op2_tag[k] <= '0;
                r_dst[k]     <= '0;
                r_ctrl[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < ENTRIES; k++) begin
                if (w_issue && (w_out_idx == c_IDX_W'(k))) begin
                    r_busy[k]  <= 1'b0;
                    r_op1_v[k] <= 1'b0;
                    r_op2_v[k] <= 1'b0;
                end else if (w_dispatch && (w_free_idx == c_IDX_W'(k))) begin
                    r_busy[k]    <= 1'b1;
                    r_op1_v[k]   <= op1_valid | w_byp1;
                    r_op2_v[k]   <= op2_valid | w_byp2;
                    r_op1_val[k] <= op1_valid ? op1_value : cdb_result;
                    r_op2_val[k] <= op2_valid ? op2_value : cdb_result;
                    r_op1_tag[k] <= op1_rs_id;
                    r_op2_tag[k] <= op2_rs_id;
                    r_dst[k]     <= result_reg_addr_in;
                    r_ctrl[k]    <= control_in;
                end else if (r_busy[k] && cdb_valid) begin
                    if (!r_op1_v[k] && (r_op1_tag[k] == cdb_rs_id)) begin
                        r_op1_v[k]   <= 1'b1;
                        r_op1_val[k] <= cdb_result;
                    end
                    if (!r_op2_v[k] && (r_op2_tag[k] == cdb_rs_id)) begin
                        r_op2_v[k]   <= 1'b1;
                        r_op2_val[k] <= cdb_result;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_reservation_station.sv
// ============================================================================
//  Module   : tb_div_reservation_station
//  Brief    : Directed self-checking bench for div_reservation_station.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_reservation_station;

    localparam int c_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic input_valid = 1'b0;
    logic input_ready;
    logic op1_valid = 1'b0, op2_valid = 1'b0;
    logic [31:0] op1_value = '0, op2_value = '0;
    logic [c_W-1:0] op1_rs_id = '0, op2_rs_id = '0;
    logic [4:0] result_reg_addr_in = '0;
    div_rs_pkg::div_decode_t control_in = '0;
    logic [c_W-1:0] alloc_rs_id;
    logic cdb_valid = 1'b0;
    logic [c_W-1:0] cdb_rs_id = '0;
    logic [31:0] cdb_result = '0;
    logic output_valid;
    logic output_ready = 1'b0;
    logic [c_W-1:0] rs_id_out;
    logic [4:0] result_reg_addr_out;
    logic [31:0] op1_out, op2_out;
    div_rs_pkg::div_decode_t control_out;

    int n_checks = 0;
    int n_fail   = 0;

    div_reservation_station #(
        .RS_ID_WIDTH (c_W),
        .ENTRIES     (4),
        .RS_ID_BASE  (8)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .input_valid         (input_valid),
        .input_ready         (input_ready),
        .op1_valid           (op1_valid),
        .op2_valid           (op2_valid),
        .op1_value           (op1_value),
        .op2_value           (op2_value),
        .op1_rs_id           (op1_rs_id),
        .op2_rs_id           (op2_rs_id),
        .result_reg_addr_in  (result_reg_addr_in),
        .control_in          (control_in),
        .alloc_rs_id         (alloc_rs_id),
        .cdb_valid           (cdb_valid),
        .cdb_rs_id           (cdb_rs_id),
        .cdb_result          (cdb_result),
        .output_valid        (output_valid),
        .output_ready        (output_ready),
        .rs_id_out           (rs_id_out),
        .result_reg_addr_out (result_reg_addr_out),
        .op1_out             (op1_out),
        .op2_out             (op2_out),
        .control_out         (control_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle dispatch offer; tag fields only matter when the value is invalid.
    task automatic dispatch(input logic v1, input logic [31:0] x1, input logic [c_W-1:0] t1,
                            input logic v2, input logic [31:0] x2, input logic [c_W-1:0] t2);
        input_valid = 1'b1;
        op1_valid = v1; op1_value = x1; op1_rs_id = t1;
        op2_valid = v2; op2_value = x2; op2_rs_id = t2;
        tick();
        input_valid = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_out_valid", output_valid, 0);
        check("rst_in_ready", input_ready, 1);
        check("rst_alloc", alloc_rs_id, 8);
        check("rst_op1_out", op1_out, 0);
        tick();
        tick();
        rst = 1'b0;

        // Both operands present: ready the cycle after dispatch
        result_reg_addr_in = 5'd3;
        control_in = 2'b10;
        check("t1_alloc_before", alloc_rs_id, 8);
        dispatch(1, 100, 0, 1, 7, 0);
        check("t1_valid", output_valid, 1);
        check("t1_rs_id", rs_id_out, 8);
        check("t1_op1", op1_out, 100);
        check("t1_op2", op2_out, 7);
        check("t1_dst", result_reg_addr_out, 3);
        check("t1_ctrl", control_out, 2);
        check("t1_alloc_next", alloc_rs_id, 9);
        output_ready = 1'b1;
        tick();
        output_ready = 1'b0;
        check("t1_issued_valid", output_valid, 0);
        check("t1_issued_alloc", alloc_rs_id, 8);

        // Operand woken by a later broadcast; a non-matching tag is ignored
        dispatch(1, 32'h8000_0000, 0, 0, 0, 3);
        check("t2_waiting", output_valid, 0);
        cdb_valid = 1'b1; cdb_rs_id = 4; cdb_result = 32'h1;
        tick();
        check("t2_other_tag", output_valid, 0);
        cdb_rs_id = 3; cdb_result = 32'hFFFF_FFFF;
        tick();
        cdb_valid = 1'b0;
        check("t2_valid", output_valid, 1);
        check("t2_op1", op1_out, 32'h8000_0000);
        check("t2_op2", op2_out, 32'hFFFF_FFFF);
        output_ready = 1'b1;
        tick();
        output_ready = 1'b0;

        // Same-cycle bypass at dispatch
        cdb_valid = 1'b1; cdb_rs_id = 5; cdb_result = 9;
        dispatch(1, 20, 0, 0, 0, 5);
        cdb_valid = 1'b0;
        check("t3_valid", output_valid, 1);
        check("t3_op1", op1_out, 20);
        check("t3_op2", op2_out, 9);
        output_ready = 1'b1;
        tick();
        output_ready = 1'b0;
        check("t3_empty", output_valid, 0);

        // Fill all slots, ignored dispatch when full, reuse after issue
        for (int i = 0; i < 4; i++) begin
            check("t4_alloc_fill", alloc_rs_id, 32'(8 + i));
            dispatch(1, 32'(i + 1), 0, 1, 2, 0);
        end
        check("t4_full", input_ready, 0);
        dispatch(1, 99, 0, 1, 99, 0);
        check("t4_head_rs", rs_id_out, 8);
        check("t4_head_op1", op1_out, 1);
        output_ready = 1'b1;
        tick();
        output_ready = 1'b0;
        check("t4_ready_again", input_ready, 1);
        check("t4_alloc_freed", alloc_rs_id, 8);
        check("t4_next_rs", rs_id_out, 9);
        check("t4_next_op1", op1_out, 2);
        // Dispatch into entry 0 while entry 1 issues
        output_ready = 1'b1;
        dispatch(1, 50, 0, 1, 2, 0);
        check("t4_sim_alloc", alloc_rs_id, 9);
        check("t4_sim_rs", rs_id_out, 8);
        check("t4_sim_op1", op1_out, 50);
        tick();
        check("t4_drain_rs_a", rs_id_out, 10);
        check("t4_drain_op1_a", op1_out, 3);
        tick();
        check("t4_drain_rs_b", rs_id_out, 11);
        check("t4_drain_op1_b", op1_out, 4);
        tick();
        output_ready = 1'b0;
        check("t4_drained", output_valid, 0);

        // Entries 0 and 2 ready with a waiting entry 1 between them
        dispatch(1, 11, 0, 1, 1, 0);
        dispatch(1, 44, 0, 0, 0, 6);
        dispatch(1, 33, 0, 1, 1, 0);
        output_ready = 1'b1;
        #1;
        check("t5_first_rs", rs_id_out, 8);
        check("t5_first_op1", op1_out, 11);
        tick();
        check("t5_second_rs", rs_id_out, 10);
        check("t5_second_op1", op1_out, 33);
        tick();
        output_ready = 1'b0;
        check("t5_only_waiter", output_valid, 0);
        // One broadcast wakes both operands of entry 0 and op2 of entry 1
        dispatch(0, 0, 6, 0, 0, 6);
        cdb_valid = 1'b1; cdb_rs_id = 6; cdb_result = 32'h1234;
        tick();
        cdb_valid = 1'b0;
        check("t5_multi_rs", rs_id_out, 8);
        check("t5_multi_op1", op1_out, 32'h1234);
        check("t5_multi_op2", op2_out, 32'h1234);
        output_ready = 1'b1;
        tick();
        check("t5_e1_rs", rs_id_out, 9);
        check("t5_e1_op1", op1_out, 44);
        check("t5_e1_op2", op2_out, 32'h1234);
        tick();
        output_ready = 1'b0;
        check("t5_empty", output_valid, 0);

        // Asynchronous reset with three entries held
        for (int i = 0; i < 3; i++) dispatch(1, 32'(70 + i), 0, 1, 1, 0);
        check("t6_held", output_valid, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", output_valid, 0);
        check("t6_rst_ready", input_ready, 1);
        check("t6_rst_alloc", alloc_rs_id, 8);
        check("t6_rst_op1", op1_out, 0);
        tick();
        rst = 1'b0;
        output_ready = 1'b1;
        tick();
        tick();
        check("t6_no_issue", output_valid, 0);
        check("t6_post_ready", input_ready, 1);
        output_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_reservation_station.md
DIV_RESERVATION_STATION -- requirements
Module: div_reservation_station

Interface
REQ-001 SHALL have parameter RS_ID_WIDTH, default 5, width of every RS ID and operand tag.
REQ-002 SHALL have parameter ENTRIES, default 4, number of station slots (2..8).
REQ-003 SHALL have parameter RS_ID_BASE, default 0, RS ID of entry 0; entry k owns ID RS_ID_BASE+k.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port input_valid  in  1  dispatch offers an instruction.
REQ-007 SHALL have port input_ready  out  1  a free entry exists.
REQ-008 SHALL have ports op1_valid/op2_valid  in  1 each  operand value present (else waiting on tag).
REQ-009 SHALL have ports op1_value/op2_value  in  32 each  operand value when valid.
REQ-010 SHALL have ports op1_rs_id/op2_rs_id  in  RS_ID_WIDTH each  producer tag when not valid.
REQ-011 SHALL have ports result_reg_addr_in  in  5 and control_in  in  div_decode_t  carried to issue unchanged.
REQ-012 SHALL have port alloc_rs_id  out  RS_ID_WIDTH  ID of the entry a dispatch would occupy this cycle.
REQ-013 SHALL have ports cdb_valid  in  1, cdb_rs_id  in  RS_ID_WIDTH, cdb_result  in  32  result broadcast.
REQ-014 SHALL have ports output_valid  out  1, output_ready  in  1  issue handshake toward the divider.
REQ-015 SHALL have ports rs_id_out  out  RS_ID_WIDTH, result_reg_addr_out  out  5, op1_out/op2_out  out  32, control_out  out  div_decode_t.

Function
REQ-016 Each entry SHALL be FREE, WAITING (an operand missing) or READY (both present).
REQ-017 input_ready SHALL be 1 iff any entry is FREE at cycle start; entries freed this cycle count from next cycle.
REQ-018 Dispatch handshake (input_valid & input_ready) SHALL write the lowest-index FREE entry; alloc_rs_id SHALL equal its ID (RS_ID_BASE when all free).
REQ-019 At dispatch, an invalid operand whose tag equals cdb_rs_id while cdb_valid=1 SHALL be captured from cdb_result (same-cycle bypass).
REQ-020 Every cycle with cdb_valid=1, each WAITING operand with matching tag SHALL latch cdb_result and become valid at the next edge.
REQ-021 An entry SHALL become READY at the edge where its last operand becomes valid; issue eligible from the following cycle.
REQ-022 output_valid SHALL be 1 iff any entry is READY; outputs SHALL reflect the lowest-index READY entry, combinationally from registered state.
REQ-023 Outputs SHALL hold stable while output_valid=1 and output_ready=0, unless a lower-index entry becomes READY at that edge.
REQ-024 Issue handshake (output_valid & output_ready) SHALL set that entry FREE at the edge.
REQ-025 Dispatch and issue in one cycle SHALL both complete; dispatch SHALL NOT reuse the entry issuing that cycle.
REQ-026 CDB tags matching no waiting operand SHALL be ignored; one broadcast MAY wake operands in several entries and both operands of one entry.
REQ-027 Operand values SHALL pass bit-exact, no sign or width conversion.
REQ-028 Dispatch with input_ready=0 SHALL be ignored, no state change.

Reset
REQ-029 rst=1 SHALL asynchronously set all entries FREE; output_valid=0, input_ready=1, alloc_rs_id=RS_ID_BASE; data outputs 0.
REQ-030 Reset mid-operation SHALL discard all held entries; nothing issues after release until new dispatches.

Verification
REQ-031 Dispatch op1=100 valid, op2=7 valid, RS_ID_BASE=8 -> next cycle output_valid=1, rs_id_out=8, op1_out=100, op2_out=7.
REQ-032 Dispatch op1=0x80000000 valid, op2 tag 3 invalid; later cdb_valid=1, tag 3, result 0xFFFFFFFF -> READY next edge, op2_out=0xFFFFFFFF.
REQ-033 Dispatch with op2 tag 5 while cdb_valid=1, cdb_rs_id=5, cdb_result=9 -> entry READY next cycle, op2_out=9.
REQ-034 Fill 4 entries with output_ready=0 -> input_ready=0, 5th dispatch ignored; one issue -> input_ready=1 next cycle, alloc_rs_id=freed ID.
REQ-035 Entries 0 and 2 READY, output_ready=1 -> entry 0 issues first, entry 2 next cycle.
REQ-036 rst asserted with 3 entries held -> output_valid=0, input_ready=1 immediately, no issue after release.
